vga_timing_ctrl: RTL and testbench
==================================

// Module: vga_timing_ctrl
// PURPOSE
//  640x480@60Hz VGA timing generator and pixel output stage, clocked at 25 MHz.
//  Runs free-running horizontal and vertical counters and drives hsync and vsync.
//  Issues a pixel request plus coordinates one cycle ahead of the active pixel,
//  because the downstream colour generator registers its colour output.
//  Drives the returned colour on rgb during the active window, and 0 elsewhere.
// PARAMETERS
//  H_SYNC   96   hsync pulse width, clocks
//  H_BACK   48   h back porch, clocks
//  H_VALID  640  active pixels per line
//  H_FRONT  16   h front porch, clocks
//  H_TOTAL  800  clocks per line (sum of the four above)
//  V_SYNC   2    vsync pulse width, lines
//  V_BACK   33   v back porch, lines
//  V_VALID  480  active lines per frame
//  V_FRONT  10   v front porch, lines
//  V_TOTAL  525  lines per frame (sum of the four above)
//  SYNC_POL 1'b0 active level of hsync and vsync (0 = active-low)
// PORTS
//  Clk_int       in   1   pixel clock, 25 MHz
//  Sys_Rst_n     in   1   asynchronous reset, active-low
//  pix_colour_in in   16  RGB565 from the colour generator; reflects the pix_x/pix_y of the previous cycle
//  pix_data_req  out  1   high one cycle before each active pixel
//  pix_x         out  10  requested x coordinate, 0..639; 10'h3FF when pix_data_req=0
//  pix_y         out  10  requested y coordinate, 0..479; 10'h3FF when pix_data_req=0
//  rgb_valid     out  1   high while the current pixel is in the active window
//  rgb           out  16  RGB565 to the DAC; pix_colour_in if rgb_valid, else 16'h0000
//  hsync         out  1   horizontal sync
//  vsync         out  1   vertical sync
//  frame_start   out  1   one-cycle pulse at each wrap of both counters to (0,0)
// BEHAVIOUR
//  Reset (Sys_Rst_n asynchronous, active-low; clock Clk_int):
//   - cnt_h=0, cnt_v=0, frame_start=0.
//   - Remaining outputs are decoded from the counters, so during reset:
//     hsync=vsync=SYNC_POL, rgb_valid=0, rgb=0, pix_data_req=0, pix_x=pix_y=10'h3FF.
//  Counters (10-bit):
//   - cnt_h: 0..H_TOTAL-1, wraps to 0.
//   - cnt_v: increments only on the cycle where cnt_h=H_TOTAL-1; wraps to 0 after V_TOTAL-1.
//   - There is no enable; counters run continuously after reset release.
//  Sync:
//   - hsync = SYNC_POL while cnt_h < H_SYNC, else ~SYNC_POL.
//   - vsync = SYNC_POL while cnt_v < V_SYNC, else ~SYNC_POL.
//  Active window:
//   - HA = H_SYNC+H_BACK = 144; VA = V_SYNC+V_BACK = 35.
//   - rgb_valid = (HA <= cnt_h < HA+H_VALID) && (VA <= cnt_v < VA+V_VALID).
//  Request:
//   - pix_data_req = (HA-1 <= cnt_h < HA+H_VALID-1) && (VA <= cnt_v < VA+V_VALID).
//   - pix_x = cnt_h-(HA-1); pix_y = cnt_v-VA.
//   - pix_data_req leads rgb_valid by exactly 1 clock.
//   - The lead never crosses a line boundary; there are no requests in vertical blanking.
//  Colour path:
//   - rgb is combinational from rgb_valid and pix_colour_in; no extra register.
//   - Total latency, coordinate to rgb, is 1 clock (spent in the colour generator).
//  frame_start:
//   - Registered; set in the cycle after cnt_h=H_TOTAL-1 && cnt_v=V_TOTAL-1,
//     i.e. coincident with counters=(0,0).
//   - Not asserted for the first frame after reset.
//  Reset mid-operation:
//   - Counters return to (0,0) immediately; outputs take their reset values.
//   - The first line after release has full timing; no partial-pixel artefact.
//  Widths:
//   - All counts and comparisons are 10 bits unsigned; H_TOTAL-1 = 799 fits.
// TESTING
//  T1 Release reset -> hsync low cycles 0..95, high 96..799; period 800 clocks, repeating.
//  T2 Run 2 frames -> vsync low for 1600 clocks; vsync period 420000 clocks;
//     frame_start pulses exactly once per 420000 clocks, none at first (0,0).
//  T3 Line cnt_v=35 -> pix_data_req rises at cnt_h=143 with pix_x=0, pix_y=0;
//     falls after cnt_h=782 with pix_x=639; 640 requests per line.
//  T4 Connect the 10-colour-bar generator -> on the first active line:
//     rgb=16'hF800 at cnt_h 144..207, 16'hFC00 at 208..271, ..., 16'hD69A at 720..783.
//  T5 Drive pix_colour_in=16'hFFFF constantly -> rgb=0 whenever rgb_valid=0;
//     480*640 white pixels per frame.
//  T6 Assert reset at cnt_h=400, cnt_v=200 -> same cycle: hsync=vsync=0, rgb=0, pix_x=10'h3FF;
//     after release, the T1 timing restarts from (0,0).

Source files
------------

// File: rtl/vga_timing_ctrl.sv
`timescale 1ns/1ps
// VGA 640x480@60Hz timing generator: free-running line/frame counters, sync decode,
// a pixel request issued one clock ahead of the active pixel, and a masked colour output.
module vga_timing_ctrl #(
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BACK   = 48,
    parameter int unsigned H_VALID  = 640,
    parameter int unsigned H_FRONT  = 16,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BACK   = 33,
    parameter int unsigned V_VALID  = 480,
    parameter int unsigned V_FRONT  = 10,
    parameter logic        SYNC_POL = 1'b0
) (
    input  logic        Clk_int,
    input  logic        Sys_Rst_n,
    input  logic [15:0] pix_colour_in,
    output logic        pix_data_req,
    output logic [9:0]  pix_x,
    output logic [9:0]  pix_y,
    output logic        rgb_valid,
    output logic [15:0] rgb,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);

    localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
    localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

    localparam logic [9:0] H_LAST      = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST      = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SYNC_END  = 10'(H_SYNC);
    localparam logic [9:0] V_SYNC_END  = 10'(V_SYNC);
    localparam logic [9:0] H_ACT_START = 10'(H_SYNC + H_BACK);
    localparam logic [9:0] H_ACT_END   = 10'(H_SYNC + H_BACK + H_VALID);
    localparam logic [9:0] V_ACT_START = 10'(V_SYNC + V_BACK);
    localparam logic [9:0] V_ACT_END   = 10'(V_SYNC + V_BACK + V_VALID);
    // The request window is the active window shifted one clock earlier on the same line.
    localparam logic [9:0] H_REQ_START = 10'(H_SYNC + H_BACK - 1);
    localparam logic [9:0] H_REQ_END   = 10'(H_SYNC + H_BACK + H_VALID - 1);

    logic [9:0] cnt_h_q, cnt_h_d;
    logic [9:0] cnt_v_q, cnt_v_d;
    logic       frame_start_q, frame_start_d;

    logic line_end;
    logic h_active;
    logic h_req;
    logic v_active;

    always_comb begin
        line_end      = (cnt_h_q == H_LAST);
        cnt_h_d       = line_end ? 10'd0 : cnt_h_q + 10'd1;
        cnt_v_d       = cnt_v_q;
        if (line_end) begin
            cnt_v_d = (cnt_v_q == V_LAST) ? 10'd0 : cnt_v_q + 10'd1;
        end
        frame_start_d = line_end && (cnt_v_q == V_LAST);
    end

    always_ff @(posedge Clk_int or negedge Sys_Rst_n) begin
        if (!Sys_Rst_n) begin
            cnt_h_q       <= 10'd0;
            cnt_v_q       <= 10'd0;
            frame_start_q <= 1'b0;
        end else begin
            cnt_h_q       <= cnt_h_d;
            cnt_v_q       <= cnt_v_d;
            frame_start_q <= frame_start_d;
        end
    end

    // Everything below decodes straight from the counters, so reset values follow for free.
    always_comb begin
        h_active     = (cnt_h_q >= H_ACT_START) && (cnt_h_q < H_ACT_END);
        h_req        = (cnt_h_q >= H_REQ_START) && (cnt_h_q < H_REQ_END);
        v_active     = (cnt_v_q >= V_ACT_START) && (cnt_v_q < V_ACT_END);

        hsync        = (cnt_h_q < H_SYNC_END) ? SYNC_POL : ~SYNC_POL;
        vsync        = (cnt_v_q < V_SYNC_END) ? SYNC_POL : ~SYNC_POL;

        rgb_valid    = h_active && v_active;
        pix_data_req = h_req && v_active;
        pix_x        = pix_data_req ? (cnt_h_q - H_REQ_START) : 10'h3FF;
        pix_y        = pix_data_req ? (cnt_v_q - V_ACT_START) : 10'h3FF;

        // The colour generator already spent the one clock of latency; no extra stage here.
        rgb          = rgb_valid ? pix_colour_in : 16'h0000;
        frame_start  = frame_start_q;
    end

endmodule

// File: tb/tb_vga_timing_ctrl.sv
`timescale 1ns/1ps
// Directed bench for vga_timing_ctrl: a full-size instance for line timing, requests, colour
// bars and mid-frame reset, and a shrunken instance for frame-level vsync/frame_start checks.
module tb_vga_timing_ctrl;

    logic        clk = 1'b0;
    always #20 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Full-size instance
    logic        rst_n;
    logic [15:0] colour_in;
    logic        req, vld, hs, vs, fs;
    logic [9:0]  px, py;
    logic [15:0] rgb;

    // Shrunken instance: line 20 clocks (4/3/10/3), frame 11 lines (2/3/4/2)
    logic        rst_s_n;
    logic [15:0] s_colour;
    logic        s_req, s_vld, s_hs, s_vs, s_fs;
    logic [9:0]  s_px, s_py;
    logic [15:0] s_rgb;

    logic        use_gen;
    logic [15:0] const_col;
    logic [15:0] gen_q;

    vga_timing_ctrl u_dut (
        .Clk_int       (clk),
        .Sys_Rst_n     (rst_n),
        .pix_colour_in (colour_in),
        .pix_data_req  (req),
        .pix_x         (px),
        .pix_y         (py),
        .rgb_valid     (vld),
        .rgb           (rgb),
        .hsync         (hs),
        .vsync         (vs),
        .frame_start   (fs)
    );

    vga_timing_ctrl #(
        .H_SYNC  (4),
        .H_BACK  (3),
        .H_VALID (10),
        .H_FRONT (3),
        .V_SYNC  (2),
        .V_BACK  (3),
        .V_VALID (4),
        .V_FRONT (2)
    ) u_small (
        .Clk_int       (clk),
        .Sys_Rst_n     (rst_s_n),
        .pix_colour_in (s_colour),
        .pix_data_req  (s_req),
        .pix_x         (s_px),
        .pix_y         (s_py),
        .rgb_valid     (s_vld),
        .rgb           (s_rgb),
        .hsync         (s_hs),
        .vsync         (s_vs),
        .frame_start   (s_fs)
    );

    function automatic logic [15:0] bar_colour(input int i);
        case (i)
            0:       return 16'hF800;
            1:       return 16'hFC00;
            2:       return 16'hFFE0;
            3:       return 16'h07E0;
            4:       return 16'h07FF;
            5:       return 16'h001F;
            6:       return 16'hF81F;
            7:       return 16'h8010;
            8:       return 16'hFFFF;
            default: return 16'hD69A;
        endcase
    endfunction

    // Registered 10-bar colour generator; junk when not requested so masking is visible.
    always @(posedge clk) gen_q <= req ? bar_colour(int'(px) / 64) : 16'h5A5A;
    assign colour_in = use_gen ? gen_q : const_col;
    assign s_colour  = 16'hFFFF;

    // Position tracker for the full-size instance, used only to pick sampling points.
    int mh, mv;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mh <= 0;
            mv <= 0;
        end else if (mh == 799) begin
            mh <= 0;
            mv <= (mv == 524) ? 0 : mv + 1;
        end else begin
            mh <= mh + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        rst_s_n   = 1'b0;
        use_gen   = 1'b0;
        const_col = 16'hFFFF;
        repeat (3) tick();
        n_vec++; if (hs !== 1'b0) begin n_err++; $display("FAIL reset_hsync got %b want 0", hs); end
        n_vec++; if (vs !== 1'b0) begin n_err++; $display("FAIL reset_vsync got %b want 0", vs); end
        n_vec++; if (vld !== 1'b0) begin n_err++; $display("FAIL reset_rgb_valid got %b want 0", vld); end
        n_vec++; if (rgb !== 16'h0) begin n_err++; $display("FAIL reset_rgb got %h want 0000", rgb); end
        n_vec++; if (req !== 1'b0) begin n_err++; $display("FAIL reset_req got %b want 0", req); end
        n_vec++; if (px !== 10'h3FF) begin n_err++; $display("FAIL reset_pix_x got %h want 3ff", px); end
        n_vec++; if (py !== 10'h3FF) begin n_err++; $display("FAIL reset_pix_y got %h want 3ff", py); end
        n_vec++; if (fs !== 1'b0) begin n_err++; $display("FAIL reset_frame_start got %b want 0", fs); end
        n_vec++; if (s_hs !== 1'b0 || s_vs !== 1'b0) begin
            n_err++; $display("FAIL reset_small_sync got %b%b want 00", s_hs, s_vs);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Called mid-cycle with the counters at (0,0): measure one hsync low/high/low sequence.
    task automatic check_line_timing(input string tag);
        int n_lo, n_hi, n_lo2;
        n_lo = 0; n_hi = 0; n_lo2 = 0;
        while (hs === 1'b0 && n_lo < 1000) begin n_lo++; tick(); end
        while (hs === 1'b1 && n_hi < 1000) begin n_hi++; tick(); end
        while (hs === 1'b0 && n_lo2 < 1000) begin n_lo2++; tick(); end
        n_vec++; if (n_lo != 96) begin n_err++; $display("FAIL %s_hsync_low got %0d want 96", tag, n_lo); end
        n_vec++; if (n_hi != 704) begin n_err++; $display("FAIL %s_hsync_high got %0d want 704", tag, n_hi); end
        n_vec++; if (n_lo2 != 96) begin n_err++; $display("FAIL %s_hsync_low2 got %0d want 96", tag, n_lo2); end
        n_vec++; if (vs !== 1'b0) begin n_err++; $display("FAIL %s_vsync_line1 got %b want 0", tag, vs); end
        n_vec++; if (req !== 1'b0 || vld !== 1'b0) begin
            n_err++; $display("FAIL %s_blank_req_valid got %b%b want 00", tag, req, vld);
        end
    endtask

    task automatic test_hsync();
        n_vec++; if (hs !== 1'b0) begin n_err++; $display("FAIL hsync_at_release got %b want 0", hs); end
        check_line_timing("t1");
    endtask

    task automatic test_request_and_bars();
        int cnt, reqs, bad, px782, req783;
        logic [15:0] rgb208, rgb783;
        use_gen = 1'b1;
        cnt = 0;
        while (!(mv == 35 && mh == 142) && cnt < 40000) begin tick(); cnt++; end
        n_vec++; if (cnt >= 40000) begin
            n_err++; $display("FAIL reach_line35 got timeout want position");
            return;
        end
        n_vec++; if (req !== 1'b0 || px !== 10'h3FF) begin
            n_err++; $display("FAIL req_h142 got req=%b x=%h want req=0 x=3ff", req, px);
        end
        tick();
        n_vec++; if (req !== 1'b1 || px !== 10'd0 || py !== 10'd0) begin
            n_err++; $display("FAIL req_h143 got req=%b x=%0d y=%0d want req=1 x=0 y=0", req, px, py);
        end
        n_vec++; if (vld !== 1'b0 || rgb !== 16'h0) begin
            n_err++; $display("FAIL valid_h143 got vld=%b rgb=%h want 0 0000", vld, rgb);
        end
        reqs = 1; bad = 0; px782 = -1; req783 = -1; rgb208 = 16'hxxxx; rgb783 = 16'hxxxx;
        for (int i = 0; i < 656; i++) begin
            logic       e_req, e_vld;
            logic [9:0] e_px;
            logic [15:0] e_rgb;
            tick();
            e_req = (mh <= 782);
            e_vld = (mh <= 783);
            e_px  = e_req ? 10'(mh - 143) : 10'h3FF;
            e_rgb = e_vld ? bar_colour((mh - 144) / 64) : 16'h0000;
            if (req === 1'b1) reqs++;
            if (req !== e_req || vld !== e_vld || px !== e_px || rgb !== e_rgb) bad++;
            if (mh == 782) px782 = int'(px);
            if (mh == 783) begin req783 = int'(req); rgb783 = rgb; end
            if (mh == 208) rgb208 = rgb;
        end
        n_vec++; if (reqs != 640) begin n_err++; $display("FAIL req_count got %0d want 640", reqs); end
        n_vec++; if (bad != 0) begin n_err++; $display("FAIL line35_cycles got %0d bad want 0", bad); end
        n_vec++; if (px782 != 639) begin n_err++; $display("FAIL pix_x_h782 got %0d want 639", px782); end
        n_vec++; if (req783 != 0) begin n_err++; $display("FAIL req_h783 got %0d want 0", req783); end
        n_vec++; if (rgb208 !== 16'hFC00) begin n_err++; $display("FAIL rgb_h208 got %h want fc00", rgb208); end
        n_vec++; if (rgb783 !== 16'hD69A) begin n_err++; $display("FAIL rgb_h783 got %h want d69a", rgb783); end
        use_gen = 1'b0;
    endtask

    task automatic test_reset_mid();
        int cnt;
        const_col = 16'hFFFF;
        cnt = 0;
        while (!(mv == 36 && mh == 400) && cnt < 2000) begin tick(); cnt++; end
        n_vec++; if (cnt >= 2000) begin
            n_err++; $display("FAIL reach_h400 got timeout want position");
            return;
        end
        n_vec++; if (vld !== 1'b1 || px !== 10'd257 || py !== 10'd1) begin
            n_err++; $display("FAIL pre_reset got vld=%b x=%0d y=%0d want 1 257 1", vld, px, py);
        end
        #5;
        rst_n = 1'b0;
        #1;
        n_vec++; if (hs !== 1'b0 || vs !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_sync got %b%b want 00", hs, vs);
        end
        n_vec++; if (rgb !== 16'h0 || vld !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_rgb got %h vld=%b want 0000 0", rgb, vld);
        end
        n_vec++; if (px !== 10'h3FF || req !== 1'b0) begin
            n_err++; $display("FAIL mid_reset_pix_x got %h req=%b want 3ff 0", px, req);
        end
        repeat (2) tick();
        @(negedge clk);
        rst_n = 1'b1;
        check_line_timing("t6");
    endtask

    task automatic test_small_frames();
        int fs_cnt, fs1, fs2, vlow, vper, last_fall, white0, white1, bad_rgb, lead_bad, req0;
        int max_x, max_y;
        logic prev_vs, prev_req;
        fs_cnt = 0; fs1 = -1; fs2 = -1; vlow = 0; vper = -1; last_fall = -1;
        white0 = 0; white1 = 0; bad_rgb = 0; lead_bad = 0; req0 = 0; max_x = 0; max_y = 0;
        prev_vs = 1'b0; prev_req = 1'b0;
        @(negedge clk);
        rst_s_n = 1'b1;
        for (int c = 0; c < 660; c++) begin
            if (s_fs === 1'b1) begin
                fs_cnt++;
                if (fs_cnt == 1) fs1 = c;
                if (fs_cnt == 2) fs2 = c;
            end
            if (s_vs === 1'b0) vlow++;
            if (prev_vs === 1'b1 && s_vs === 1'b0) begin
                if (last_fall >= 0) vper = c - last_fall;
                last_fall = c;
            end
            if (s_vld === 1'b1 && s_rgb === 16'hFFFF) begin
                if (c < 220) white0++;
                else if (c < 440) white1++;
            end
            if (s_vld !== 1'b1 && s_rgb !== 16'h0) bad_rgb++;
            if (s_vld !== prev_req) lead_bad++;
            if (s_req === 1'b1) begin
                if (c < 220) req0++;
                if (int'(s_px) > max_x) max_x = int'(s_px);
                if (int'(s_py) > max_y) max_y = int'(s_py);
            end
            prev_vs  = s_vs;
            prev_req = s_req;
            tick();
        end
        n_vec++; if (fs_cnt != 2) begin n_err++; $display("FAIL fs_count got %0d want 2", fs_cnt); end
        n_vec++; if (fs1 != 220) begin n_err++; $display("FAIL fs_first got %0d want 220", fs1); end
        n_vec++; if (fs2 != 440) begin n_err++; $display("FAIL fs_second got %0d want 440", fs2); end
        n_vec++; if (vlow != 120) begin n_err++; $display("FAIL vsync_low got %0d want 120", vlow); end
        n_vec++; if (vper != 220) begin n_err++; $display("FAIL vsync_period got %0d want 220", vper); end
        n_vec++; if (white0 != 40) begin n_err++; $display("FAIL white_f0 got %0d want 40", white0); end
        n_vec++; if (white1 != 40) begin n_err++; $display("FAIL white_f1 got %0d want 40", white1); end
        n_vec++; if (bad_rgb != 0) begin n_err++; $display("FAIL rgb_masking got %0d want 0", bad_rgb); end
        n_vec++; if (lead_bad != 0) begin n_err++; $display("FAIL req_lead got %0d want 0", lead_bad); end
        n_vec++; if (req0 != 40) begin n_err++; $display("FAIL req_per_frame got %0d want 40", req0); end
        n_vec++; if (max_x != 9 || max_y != 3) begin
            n_err++; $display("FAIL coord_range got x=%0d y=%0d want 9 3", max_x, max_y);
        end
    endtask

    initial begin
        test_reset();
        test_hsync();
        test_request_and_bars();
        test_reset_mid();
        test_small_frames();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
